exec_stage: RTL and testbench

//  RV64I execute stage, directly downstream of instruction decode. Registers decode outputs on

---
 rtl/exec_stage.sv | 165 ++++++++++++++++
 tb/tb_exec_stage.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_stage.sv
// RV64I execute stage: registers decode outputs, runs the ALU / address adder with two-level
// operand bypass, resolves conditional branches and squashes wrong-path instructions.
module exec_stage #(
  parameter int SQUASH_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [63:0] op1,
  input  logic [63:0] op2,
  input  logic        imm_flag,
  input  logic        write_back,
  input  logic        mem_acc,
  input  logic        load_flag,
  input  logic        branch_flag,
  input  logic [63:0] branch_offset,
  input  logic [63:0] PC_i,
  input  logic [4:0]  mem_rd,
  input  logic [63:0] mem_value,
  input  logic        mem_en,
  output logic [63:0] alu_result,
  output logic [4:0]  rd_o,
  output logic [2:0]  funct3_o,
  output logic        write_back_o,
  output logic        mem_acc_o,
  output logic        load_flag_o,
  output logic        branch_taken,
  output logic [63:0] branch_target,
  output logic        flush
);

  logic [63:0] aluResult_q, aluResult_d;
  logic [4:0]  rd_q, rd_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        wb_q, wb_d;
  logic        memAcc_q, memAcc_d;
  logic        load_q, load_d;
  logic        taken_q, taken_d;
  logic [63:0] target_q, target_d;
  logic [1:0]  squashCnt_q, squashCnt_d;

  logic [63:0] opA, opB, sraResult, aluValue;
  logic [5:0]  shamt;
  logic        isSub, isSra, branchCond, bubble, ownResultValid;
  logic        unusedFunct7;

  // Only funct7[5] selects SUB/SRA; the remaining bits carry no meaning here.
  assign unusedFunct7 = ^{funct7[6], funct7[4:0]};

  assign ownResultValid = wb_q && !load_q;

  // Own previous result beats the memory-stage value; loads only arrive via the memory stage.
  always_comb begin
    opA = op1;
    if (rs1 != 5'd0 && ownResultValid && rd_q == rs1) begin
      opA = aluResult_q;
    end else if (rs1 != 5'd0 && mem_en && mem_rd == rs1) begin
      opA = mem_value;
    end
    opB = op2;
    if (!imm_flag && rs2 != 5'd0 && ownResultValid && rd_q == rs2) begin
      opB = aluResult_q;
    end else if (!imm_flag && rs2 != 5'd0 && mem_en && mem_rd == rs2) begin
      opB = mem_value;
    end
  end

  assign shamt     = opB[5:0];
  assign isSub     = !imm_flag && funct7[5];
  assign isSra     = imm_flag ? opB[10] : funct7[5];
  assign sraResult = $signed(opA) >>> shamt;

  always_comb begin
    aluValue = opA + opB;
    if (!mem_acc) begin
      case (funct3)
        3'b000:  aluValue = isSub ? (opA - opB) : (opA + opB);
        3'b001:  aluValue = opA << shamt;
        3'b010:  aluValue = {63'd0, $signed(opA) < $signed(opB)};
        3'b011:  aluValue = {63'd0, opA < opB};
        3'b100:  aluValue = opA ^ opB;
        3'b101:  aluValue = isSra ? sraResult : (opA >> shamt);
        3'b110:  aluValue = opA | opB;
        default: aluValue = opA & opB;
      endcase
    end
  end

  always_comb begin
    case (funct3)
      3'b000:  branchCond = (opA == opB);
      3'b001:  branchCond = (opA != opB);
      3'b100:  branchCond = ($signed(opA) < $signed(opB));
      3'b101:  branchCond = !($signed(opA) < $signed(opB));
      3'b110:  branchCond = (opA < opB);
      3'b111:  branchCond = !(opA < opB);
      default: branchCond = 1'b0;
    endcase
  end

  assign bubble = (squashCnt_q != 2'd0);

  // While the squash counter runs, the sampled instruction is turned into a bubble and
  // cannot redirect again, so a wrong-path branch never reloads the counter.
  always_comb begin
    aluResult_d = aluValue;
    funct3_d    = funct3;
    target_d    = PC_i + branch_offset;
    rd_d        = rd;
    wb_d        = write_back && !branch_flag;
    memAcc_d    = mem_acc && !branch_flag;
    load_d      = load_flag;
    taken_d     = branch_flag && branchCond;
    squashCnt_d = 2'd0;
    if (bubble) begin
      rd_d        = 5'd0;
      wb_d        = 1'b0;
      memAcc_d    = 1'b0;
      load_d      = 1'b0;
      taken_d     = 1'b0;
      squashCnt_d = squashCnt_q - 2'd1;
    end else if (taken_d) begin
      squashCnt_d = 2'(SQUASH_CYCLES);
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      aluResult_q <= 64'd0;
      rd_q        <= 5'd0;
      funct3_q    <= 3'd0;
      wb_q        <= 1'b0;
      memAcc_q    <= 1'b0;
      load_q      <= 1'b0;
      taken_q     <= 1'b0;
      target_q    <= 64'd0;
      squashCnt_q <= 2'd0;
    end else begin
      aluResult_q <= aluResult_d;
      rd_q        <= rd_d;
      funct3_q    <= funct3_d;
      wb_q        <= wb_d;
      memAcc_q    <= memAcc_d;
      load_q      <= load_d;
      taken_q     <= taken_d;
      target_q    <= target_d;
      squashCnt_q <= squashCnt_d;
    end
  end

  assign alu_result    = aluResult_q;
  assign rd_o          = rd_q;
  assign funct3_o      = funct3_q;
  assign write_back_o  = wb_q;
  assign mem_acc_o     = memAcc_q;
  assign load_flag_o   = load_q;
  assign branch_taken  = taken_q;
  assign branch_target = target_q;
  assign flush         = bubble;

endmodule

// File: tb/tb_exec_stage.sv
// Scoreboard bench for exec_stage: directed cases plus random instructions, each checked
// against a behavioural model of the execute-stage rules.
module tb_exec_stage;

  localparam int SQ = 2;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  rd, rs1, rs2, mem_rd;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [63:0] op1, op2, branch_offset, PC_i, mem_value;
  logic        imm_flag, write_back, mem_acc, load_flag, branch_flag, mem_en;
  logic [63:0] alu_result, branch_target;
  logic [4:0]  rd_o;
  logic [2:0]  funct3_o;
  logic        write_back_o, mem_acc_o, load_flag_o, branch_taken, flush;

  exec_stage #(.SQUASH_CYCLES(SQ)) dut (
    .CLK(CLK), .reset(reset), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7(funct7), .op1(op1), .op2(op2), .imm_flag(imm_flag), .write_back(write_back),
    .mem_acc(mem_acc), .load_flag(load_flag), .branch_flag(branch_flag),
    .branch_offset(branch_offset), .PC_i(PC_i), .mem_rd(mem_rd), .mem_value(mem_value),
    .mem_en(mem_en), .alu_result(alu_result), .rd_o(rd_o), .funct3_o(funct3_o),
    .write_back_o(write_back_o), .mem_acc_o(mem_acc_o), .load_flag_o(load_flag_o),
    .branch_taken(branch_taken), .branch_target(branch_target), .flush(flush)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0]  rd, rs1, rs2, mrd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] op1, op2, off, pc, mval;
    logic        imm, wb, mac, ld, br, men;
  } instr_t;

  typedef struct {
    logic        chkAlu, chkTarget, chkF3;
    logic [63:0] alu, target;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        wb, mac, ld, taken, flushExp;
  } expect_t;

  expect_t     sbQ[$];
  expect_t     monExp;
  int          compared = 0;
  int          mismatched = 0;

  // Model state: remaining squash slots and the previous instruction's forwardable result.
  int          modelSquash = 0;
  logic        prevWrites = 1'b0;
  logic [4:0]  prevRd = 5'd0;
  logic [63:0] prevVal = 64'd0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] resolve(input logic [4:0] idx, input logic [63:0] given,
                                          input instr_t in);
    if (idx == 5'd0) return given;
    if (prevWrites && prevRd == idx) return prevVal;
    if (in.men && in.mrd == idx) return in.mval;
    return given;
  endfunction

  function automatic expect_t modelStep(input instr_t in);
    expect_t     e;
    logic [63:0] a, b;
    longint      sa, sb, sr;
    logic        cond;
    e = '{default: '0};
    if (modelSquash > 0) begin
      modelSquash--;
      prevWrites = 1'b0;
      e.flushExp = (modelSquash != 0);
      return e;
    end
    a  = resolve(in.rs1, in.op1, in);
    b  = in.imm ? in.op2 : resolve(in.rs2, in.op2, in);
    sa = a;
    sb = b;
    sr = sa >>> b[5:0];
    if (in.mac) e.alu = a + b;
    else begin
      case (in.f3)
        3'd0: e.alu = (!in.imm && in.f7[5]) ? a - b : a + b;
        3'd1: e.alu = a << b[5:0];
        3'd2: e.alu = (sa < sb) ? 64'd1 : 64'd0;
        3'd3: e.alu = (a < b) ? 64'd1 : 64'd0;
        3'd4: e.alu = a ^ b;
        3'd5: e.alu = (in.imm ? b[10] : in.f7[5]) ? sr : a >> b[5:0];
        3'd6: e.alu = a | b;
        default: e.alu = a & b;
      endcase
    end
    case (in.f3)
      3'd0: cond = (a == b);
      3'd1: cond = (a != b);
      3'd4: cond = (sa < sb);
      3'd5: cond = (sa >= sb);
      3'd6: cond = (a < b);
      3'd7: cond = (a >= b);
      default: cond = 1'b0;
    endcase
    e.chkAlu = !in.br;
    e.chkF3  = 1'b1;
    e.f3     = in.f3;
    e.rd     = in.rd;
    e.wb     = in.wb && !in.br;
    e.mac    = in.mac && !in.br;
    e.ld     = in.ld;
    if (in.br && cond) begin
      e.taken     = 1'b1;
      e.chkTarget = 1'b1;
      e.target    = in.pc + in.off;
      modelSquash = SQ;
    end
    prevWrites = e.wb && !e.ld;
    prevRd     = in.rd;
    prevVal    = e.alu;
    e.flushExp = (modelSquash != 0);
    return e;
  endfunction

  function automatic instr_t mkNop();
    instr_t t;
    t = '{default: '0};
    return t;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  function automatic instr_t mkRandom();
    instr_t     t;
    int         kind;
    logic [11:0] imm12;
    t      = mkNop();
    kind   = int'($urandom_range(0, 9));
    t.rd   = 5'($urandom_range(0, 3));
    t.rs1  = 5'($urandom_range(0, 3));
    t.rs2  = 5'($urandom_range(0, 3));
    t.f3   = 3'($urandom_range(0, 7));
    t.f7   = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    t.op1  = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 5)) : rnd64();
    t.op2  = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 5)) : rnd64();
    t.men  = 1'($urandom_range(0, 1));
    t.mrd  = 5'($urandom_range(0, 3));
    t.mval = rnd64();
    t.pc   = rnd64();
    t.off  = rnd64();
    imm12  = 12'($urandom());
    if (kind <= 3) t.wb = 1'b1;
    else if (kind <= 5) begin
      t.wb = 1'b1; t.imm = 1'b1; t.op2 = {{52{imm12[11]}}, imm12};
    end else if (kind == 6) begin
      t.wb = 1'b1; t.imm = 1'b1; t.mac = 1'b1; t.ld = 1'b1; t.op2 = {{52{imm12[11]}}, imm12};
    end else if (kind == 7) begin
      t.imm = 1'b1; t.mac = 1'b1; t.op2 = {{52{imm12[11]}}, imm12};
    end else begin
      t.br = 1'b1;
      t.wb = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) t.op2 = t.op1;
    end
    return t;
  endfunction

  task automatic driveInputs(input instr_t t);
    rd = t.rd; rs1 = t.rs1; rs2 = t.rs2; funct3 = t.f3; funct7 = t.f7;
    op1 = t.op1; op2 = t.op2; imm_flag = t.imm; write_back = t.wb; mem_acc = t.mac;
    load_flag = t.ld; branch_flag = t.br; branch_offset = t.off; PC_i = t.pc;
    mem_rd = t.mrd; mem_value = t.mval; mem_en = t.men;
  endtask

  // Decode drives on the falling edge; the expected response is queued for the monitor.
  task automatic applyStimulus(input instr_t t);
    @(negedge CLK);
    driveInputs(t);
    sbQ.push_back(modelStep(t));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " alu_result"}, alu_result, 64'd0);
    checkOutput({tag, " rd_o"}, 64'(rd_o), 64'd0);
    checkOutput({tag, " funct3_o"}, 64'(funct3_o), 64'd0);
    checkOutput({tag, " write_back_o"}, 64'(write_back_o), 64'd0);
    checkOutput({tag, " mem_acc_o"}, 64'(mem_acc_o), 64'd0);
    checkOutput({tag, " load_flag_o"}, 64'(load_flag_o), 64'd0);
    checkOutput({tag, " branch_taken"}, 64'(branch_taken), 64'd0);
    checkOutput({tag, " branch_target"}, branch_target, 64'd0);
    checkOutput({tag, " flush"}, 64'(flush), 64'd0);
  endtask

  // Pulse reset between edges so no stale instruction is captured around it.
  task automatic doReset(input string tag);
    @(posedge CLK);
    #3;
    reset = 1'b0;
    #1;
    checkAllZero(tag);
    modelSquash = 0;
    prevWrites  = 1'b0;
    reset = 1'b1;
  endtask

  always @(posedge CLK) begin
    #1;
    if (reset && sbQ.size() != 0) begin
      monExp = sbQ.pop_front();
      checkOutput("rd_o", 64'(rd_o), 64'(monExp.rd));
      checkOutput("write_back_o", 64'(write_back_o), 64'(monExp.wb));
      checkOutput("mem_acc_o", 64'(mem_acc_o), 64'(monExp.mac));
      checkOutput("load_flag_o", 64'(load_flag_o), 64'(monExp.ld));
      checkOutput("branch_taken", 64'(branch_taken), 64'(monExp.taken));
      checkOutput("flush", 64'(flush), 64'(monExp.flushExp));
      if (monExp.chkAlu) checkOutput("alu_result", alu_result, monExp.alu);
      if (monExp.chkF3) checkOutput("funct3_o", 64'(funct3_o), 64'(monExp.f3));
      if (monExp.chkTarget) checkOutput("branch_target", branch_target, monExp.target);
    end
  end

  initial begin
    instr_t t;
    driveInputs(mkNop());
    #2 reset = 1'b0;
    #1 checkAllZero("initial reset");
    @(posedge CLK);
    #1 checkAllZero("reset held over edge");
    #2 reset = 1'b1;

    t = mkNop(); t.rd = 5'd5; t.op1 = 64'd5; t.op2 = 64'd7; t.wb = 1'b1; applyStimulus(t);
    t.rd = 5'd6; t.f7 = 7'h20; applyStimulus(t);
    t = mkNop(); t.rd = 5'd7; t.f3 = 3'd5; t.imm = 1'b1; t.wb = 1'b1;
    t.op1 = 64'h8000_0000_0000_0000; t.op2 = 64'h401; applyStimulus(t);
    t = mkNop(); t.rd = 5'd8; t.f3 = 3'd3; t.op1 = '1; t.op2 = 64'd1; t.wb = 1'b1; applyStimulus(t);

    t = mkNop(); t.rd = 5'd1; t.op1 = 64'd1; t.op2 = 64'd2; t.wb = 1'b1; applyStimulus(t);
    t = mkNop(); t.rd = 5'd2; t.rs1 = 5'd1; t.rs2 = 5'd1; t.wb = 1'b1; applyStimulus(t);
    t = mkNop(); t.rd = 5'd1; t.op1 = 64'd3; t.wb = 1'b1; applyStimulus(t);
    t = mkNop(); t.rd = 5'd3; t.rs1 = 5'd1; t.rs2 = 5'd1; t.wb = 1'b1;
    t.men = 1'b1; t.mrd = 5'd1; t.mval = 64'd9; applyStimulus(t);
    t.rd = 5'd4; applyStimulus(t);
    t = mkNop(); t.rd = 5'd0; t.op1 = 64'd10; t.wb = 1'b1; applyStimulus(t);
    t = mkNop(); t.rd = 5'd9; t.op1 = 64'd1; t.op2 = 64'd1; t.wb = 1'b1;
    t.men = 1'b1; t.mrd = 5'd0; t.mval = 64'd100; applyStimulus(t);

    t = mkNop(); t.br = 1'b1; t.op1 = 64'd4; t.op2 = 64'd4; t.pc = 64'h100; t.off = -64'sd8;
    applyStimulus(t);
    for (int i = 0; i < 3; i++) begin
      t = mkNop(); t.rd = 5'(10 + i); t.op1 = 64'(i + 1); t.wb = 1'b1; applyStimulus(t);
    end

    t = mkNop(); t.br = 1'b1; t.op1 = 64'd4; t.op2 = 64'd4; t.pc = 64'h200; t.off = 64'h40;
    applyStimulus(t);
    t = mkNop(); t.br = 1'b1; t.f3 = 3'd1; t.op1 = 64'd1; t.op2 = 64'd2; t.pc = 64'h300;
    applyStimulus(t);
    applyStimulus(mkNop());
    t = mkNop(); t.rd = 5'd14; t.op1 = 64'd8; t.wb = 1'b1; applyStimulus(t);

    t = mkNop(); t.rd = 5'd13; t.f3 = 3'd3; t.imm = 1'b1; t.mac = 1'b1; t.ld = 1'b1;
    t.wb = 1'b1; t.op1 = 64'h1000; t.op2 = -64'sd16; applyStimulus(t);
    t = mkNop(); t.rd = 5'd15; t.rs1 = 5'd13; t.op1 = 64'd1; t.wb = 1'b1;
    t.men = 1'b1; t.mrd = 5'd13; t.mval = 64'd55; applyStimulus(t);

    t = mkNop(); t.rd = 5'd14; t.op1 = 64'd20; t.op2 = 64'd22; t.wb = 1'b1; applyStimulus(t);
    doReset("mid-stream reset");
    t = mkNop(); t.rd = 5'd15; t.rs1 = 5'd14; t.op1 = 64'd1; t.op2 = 64'd1; t.wb = 1'b1;
    applyStimulus(t);

    t = mkNop(); t.br = 1'b1; t.op1 = 64'd7; t.op2 = 64'd7; t.pc = 64'h400; t.off = 64'h10;
    applyStimulus(t);
    doReset("mid-squash reset");
    t = mkNop(); t.rd = 5'd16; t.op1 = 64'd30; t.op2 = 64'd12; t.wb = 1'b1; applyStimulus(t);

    for (int i = 0; i < 400; i++) applyStimulus(mkRandom());

    repeat (3) @(posedge CLK);
    #2;
    checkOutput("scoreboard drained", 64'(sbQ.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
